// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch/sequencing stage: sequencer
// state encoding, instruction field geometry and special opcodes.
package fetch_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fs_state_e;

    // Opcode occupies the top OP_W bits of the instruction word;
    // the C field occupies the low PC_W bits.
    localparam int          OP_W    = 6;
    localparam logic [5:0]  OP_HALT = 6'b111111;

    // IR value after reset: OP 6'b101000, which the decoder treats as a no-op
    localparam logic [15:0] IR_NOP  = 16'hA000;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch and sequencing stage. Fetches one instruction word over
// a req/ack handshake, holds it in IR for the decoder, issues a one-cycle
// commit strobe per instruction and advances the PC (sequential or branch).
// Stops permanently on HALT until reset.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter int              IW       = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,

    output logic [5:0]      OP,
    output logic [PC_W-1:0] C,
    output logic [PC_W-1:0] pc,
    output logic            exec_en,
    input  logic            exec_stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,

    output logic            halted,
    output logic [15:0]     instret
);

    fs_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [15:0]     instret_q, instret_d;

    logic            is_halt_op;
    logic            fetch_done;

    assign is_halt_op = (ir_q[IW-1 -: OP_W] == OP_HALT);
    // Ack only counts while we are actually requesting
    assign fetch_done = (state_q == ST_FETCH) && imem_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a commit leaves EXEC either to HALT or to the next fetch
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC:  if (exec_en)  state_d = is_halt_op ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register; exec_en also drops on stall and
    // while reset is asserted so a reset cycle never commits an instruction
    always_comb begin
        imem_req = (state_q == ST_FETCH);
        exec_en  = (state_q == ST_EXEC) && !exec_stall && !rst;
        halted   = (state_q == ST_HALT);
    end

    // Datapath next values: IR load on ack, PC/instret update on commit
    always_comb begin
        ir_d      = ir_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        if (fetch_done) ir_d = imem_data;
        if (exec_en) begin
            instret_d = instret_q + 16'd1;
            if (!is_halt_op)
                pc_d = br_taken ? br_target : pc_q + PC_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= IW'(IR_NOP);
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign OP        = ir_q[IW-1 -: OP_W];
    assign C         = ir_q[PC_W-1:0];
    assign instret   = instret_q;

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch and sequencing stage directly upstream of the opcode decoder in the accumulator CPU. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and holds the current instruction. It presents OP/C to the decoder and pulses `exec_en` for one cycle per instruction. It advances the PC using the decoder's `br_taken` and the ALU-computed branch target, and stops permanently on HALT (OP 6'b111111).

## Interface
- `PC_W`, 10, PC and imem address width
- `IW`, 16, instruction width; OP = IR[IW-1:IW-6], C = IR[PC_W-1:0]
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  PC_W  fetch address, equals `pc` while `imem_req`=1
- `imem_ack`  in  1  data valid this cycle; ignored when `imem_req`=0
- `imem_data`  in  IW  instruction word, sampled when `imem_req`&`imem_ack`
- `OP`  out  6  opcode to decoder
- `C`  out  PC_W  immediate/offset field to ALU operand mux
- `pc`  out  PC_W  address of the current instruction (ALU `sel_A` = pc source)
- `exec_en`  out  1  one-cycle commit strobe; acc/flag writes qualify on it
- `exec_stall`  in  1  data-side access pending; holds EXEC
- `br_taken`  in  1  from decoder, sampled in the EXEC cycle when `exec_en`=1
- `br_target`  in  PC_W  ALU result (pc+C), sampled with `br_taken`
- `halted`  out  1  high once HALT has executed
- `instret`  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset. Unconditionally goes to FETCH on the next cycle.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1, latch IR ← `imem_data` and go to EXEC. Otherwise stay, with address stable.
- EXEC: `exec_en` = !`exec_stall`. While stalled, stay and hold IR/pc. When `exec_en`=1:
  - `instret` increments, wrapping at 2^16.
  - If OP==6'b111111, go to HALT; pc is unchanged.
  - Otherwise pc ← `br_taken` ? `br_target` : pc+1, both modulo 2^PC_W (pc+1 wraps to 0), and go to FETCH.
- HALT: `halted`=1, `imem_req`=0, `exec_en`=0. Only `rst` leaves HALT.
- `imem_req`, `exec_en` and `halted` are decoded from the state register only, with no input-to-output combinational path. Exception: `exec_en` includes `exec_stall`.
- OP/C/pc outputs are registered and stable for the whole EXEC phase, so the decoder's outputs are valid throughout EXEC.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, IR=16'hA000 (OP 6'b101000, a no-effect opcode), `imem_req`=0, `exec_en`=0, `halted`=0, `instret`=0.
- First `imem_req` is asserted in the 2nd cycle after `rst` deasserts.
- Minimum instruction period is 2 cycles: FETCH with same-cycle ack, then EXEC. Each extra ack wait or stall cycle adds 1.
- New pc is visible the cycle after `exec_en`, together with `imem_req`=1.
- `rst` asserted in any state, including mid-FETCH with no ack or stalled EXEC, takes effect at the next edge:
  - Any ack arriving in that same cycle is discarded.
  - No `exec_en` pulse is issued that cycle.
  - Memory must tolerate an abandoned request.
- `br_taken` and `br_target` are don't-care outside `exec_en` cycles.

## Structure
- Shared header (alongside signal.vh):
  - state encodings
  - `OP_HALT` = 6'b111111
  - `IR_NOP` = 16'hA000
  - instruction field positions
- Single module with no sub-module required; next-pc mux and `instret` stay inline.

## Test plan
- Reset then fetch: release `rst`; ack immediately at every request. Expect `imem_addr` 0,1,2 and one `exec_en` every 2 cycles; `instret`=3 after 3 instructions.
- Ack latency: ack 3 cycles after `imem_req`. Expect `imem_addr` held constant for 4 cycles, IR loaded from ack-cycle data only, and `exec_en` exactly once.
- Branch: at pc=5 execute OP 6'b110000 with `br_taken`=1, `br_target`=0x020. Next `imem_addr`=0x020. Repeat with `br_taken`=0: next `imem_addr`=6.
- Wrap and stall: pc=0x3FF, `exec_stall` high for 2 cycles. Expect `exec_en` low for 2 cycles, then one pulse; next `imem_addr`=0x000.
- Halt: fetch 16'hFC00. Expect one `exec_en`, `halted`=1, `imem_req` stays 0 for 20 cycles, `instret` frozen. Then `rst` gives pc=0 and `halted`=0.
- Reset mid-fetch: assert `rst` in a FETCH cycle with `imem_ack`=1. Expect IR=16'hA000, no `exec_en`, and state IDLE next cycle.
